// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and default width for the sequential multiplier
package seq_mul_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/seq_mul_addn.sv
// addn: N-bit ripple-carry adder built from a chain of full-adder cells
module addn #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-and-add multiplier, one partial product per cycle, signed/unsigned
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   r
);
    mul_state_t           state, state_next;
    logic [WIDTH:0]       mag_a, mag_b, mcand, pp, sum;
    logic [2*WIDTH:0]     acc, acc_next;
    logic [2*WIDTH-1:0]   prod;
    logic [CNT_W-1:0]     cnt;
    logic                 neg, cout, last;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -{1'b1, a} : {1'b0, a};
    assign mag_b = (is_signed && b[WIDTH-1]) ? -{1'b1, b} : {1'b0, b};
    // acc = {upper half incl. carry, multiplier}; acc[0] is the current multiplier bit
    assign pp = acc[0] ? mcand : '0;
    addn #(.N(WIDTH + 1)) u_add (
        .a   (acc[2*WIDTH:WIDTH]),
        .b   (pp),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );
    assign acc_next = {cout, sum, acc[WIDTH-1:1]};
    assign prod     = acc_next[2*WIDTH-1:0];
    assign last     = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE) state_next = in_valid ? BUSY : IDLE;
        else if (state == BUSY) state_next = last ? DONE : BUSY;
        else if (state == DONE) state_next = out_ready ? IDLE : DONE;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            r     <= '0;
        end else if (state == IDLE && in_valid) begin
            mcand <= mag_a;
            acc   <= {(WIDTH)'(0), mag_b};
            neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last) r <= neg ? -prod : prod;
        end
    end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed vector table plus handshake, backpressure, reset-abort and random checks
module tb_seq_mul;
    logic        clk = 0, reset = 1, in_valid = 0, is_signed = 0, out_ready = 0;
    logic [7:0]  a = 0, b = 0;
    logic        in_ready, out_valid;
    logic [15:0] r;
    int          nvec = 0, nerr = 0;

    typedef struct {
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] r;
    } vec_t;
    vec_t vt[12];

    seq_mul #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .r(r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input logic [15:0] er, input int stall, input bit hold);
        int n;
        @(negedge clk);
        a = ta; b = tb_; is_signed = ts; in_valid = 1; out_ready = (stall == 0);
        chk("in_ready_idle", 32'(in_ready), 1);
        @(negedge clk);
        if (!hold) in_valid = 0;
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 8);
        chk("product", 32'(r), 32'(er));
        in_valid = 0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'(i % 2);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_r", 32'(r), 32'(er));
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready), 1);
        chk("out_valid_after", 32'(out_valid), 0);
        chk("r_kept", 32'(r), 32'(er));
        out_ready = 0;
    endtask

    initial begin
        vt[0]  = '{8'd3,   8'd5,   1'b0, 16'h000F};
        vt[1]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vt[2]  = '{8'hFD,  8'h07,  1'b1, 16'hFFEB};
        vt[3]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vt[4]  = '{8'h00,  8'hFF,  1'b1, 16'h0000};
        vt[5]  = '{8'h80,  8'h80,  1'b0, 16'h4000};
        vt[6]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
        vt[7]  = '{8'hFF,  8'h01,  1'b0, 16'h00FF};
        vt[8]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vt[9]  = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
        vt[10] = '{8'h06,  8'h07,  1'b0, 16'h002A};
        vt[11] = '{8'h05,  8'hFE,  1'b1, 16'hFFF6};

        repeat (2) @(negedge clk);
        reset = 0;
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_r", 32'(r), 0);

        foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].s, vt[i].r, 0, 0);

        // backpressure with ignored in_valid pulses, then in_valid held through BUSY
        do_op(8'hFD, 8'h07, 1'b1, 16'hFFEB, 5, 0);
        do_op(8'h02, 8'h03, 1'b0, 16'h0006, 0, 1);

        // reset in the fourth BUSY cycle aborts the operation
        begin
            bit seen = 0;
            @(negedge clk);
            a = 8'd9; b = 8'd9; is_signed = 0; in_valid = 1; out_ready = 1;
            @(negedge clk);
            in_valid = 0;
            repeat (3) @(negedge clk);
            reset = 1;
            @(negedge clk);
            reset = 0;
            chk("abort_in_ready", 32'(in_ready), 1);
            chk("abort_out_valid", 32'(out_valid), 0);
            chk("abort_r", 32'(r), 0);
            repeat (12) begin
                @(negedge clk);
                seen |= out_valid;
            end
            chk("abort_no_result", 32'(seen), 0);
            out_ready = 0;
        end
        do_op(8'd6, 8'd7, 1'b0, 16'h002A, 0, 0);

        for (int k = 0; k < 300; k++) begin
            logic [7:0]  ra, rb;
            logic        rs;
            logic [15:0] ea, eb;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (k % 10 == 0) ra = 8'h80;
            ea = rs ? {{8{ra[7]}}, ra} : {8'h00, ra};
            eb = rs ? {{8{rb[7]}}, rb} : {8'h00, rb};
            do_op(ra, rb, rs, 16'(ea * eb), $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Iterative shift-and-add multiplier, generalised from the fixed 2x2 combinational multiplier to WIDTH-bit operands.
- Computes one partial product per cycle.
- Supports unsigned and signed (two's complement) modes, selected per transaction.
- Valid/ready handshakes on input and output, so it sits between pipeline stages of the ALU datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal: 2..32); result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands and mode valid.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier.
- is_signed, input, 1, 1 = treat a and b as two's complement; 0 = unsigned.
- out_valid, output, 1, r holds a finished product.
- out_ready, input, 1, consumer accepts r.
- r, output, 2*WIDTH, product a*b.

Behaviour:
- Reset (synchronous, sampled on a clk rising edge with reset=1):
  - state=IDLE, in_ready=1, out_valid=0, r=0, counter=0, internal registers=0.
  - Reset overrides all other inputs in that cycle.
  - Reset during BUSY or DONE aborts the operation; no out_valid is produced for it.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, capture operands:
    - unsigned mode: mcand=a, mplier=b, neg=0.
    - signed mode: mcand=|a|, mplier=|b|, neg=a[MSB]^b[MSB].
    - Magnitudes are computed in WIDTH+1 bits so |-2^(WIDTH-1)| is exact.
  - Then acc=0, counter=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each edge: if mplier[0]=1, add mcand to the upper half of acc, keeping the carry.
  - Shift acc and mplier right one bit; counter+1.
  - On the edge where counter==WIDTH-1: r = neg ? -acc_final : acc_final (mod 2^(2*WIDTH)), go to DONE.
- DONE:
  - out_valid=1, in_ready=0; r stable.
  - Holds indefinitely while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0; r keeps its value until the next completion.
- Latency and throughput:
  - Accept edge E0; out_valid is visible after edge E0+WIDTH.
  - With out_ready held at 1, one result every WIDTH+2 cycles.
  - No overlap of consecutive operations; in_ready is never 1 while out_valid is 1.
- Arithmetic:
  - Exact 2*WIDTH-bit product; no overflow is possible.
  - Signed result is the two's complement product in 2*WIDTH bits.
  - A zero operand still takes the full WIDTH cycles (fixed latency, no early exit).
- Boundary cases:
  - out_ready=1 arriving earlier than DONE has no effect.
  - in_valid held high through BUSY does not start a second operation; it is accepted in the first IDLE cycle.
  - is_signed=1 with a=b=-2^(WIDTH-1) gives +2^(2*WIDTH-2).

Decomposition:
- Package seq_mul_pkg: typedef enum logic[1:0] {IDLE, BUSY, DONE} mul_state_t; localparam defaults for WIDTH.
- Sub-module addn:
  - (WIDTH+1)-bit ripple adder chained from the existing full-adder cell.
  - Ports a, b, cin, sum, cout; used for the partial-product accumulation.
- Final negation and operand magnitudes use plain assign arithmetic in seq_mul.

Test Plan:
- WIDTH=8, unsigned, a=3, b=5, out_ready=1 -> out_valid exactly 8 cycles after accept, r=16'h000F, then in_ready=1 one cycle after the handshake.
- Unsigned a=255, b=255 -> r=16'hFE01; signed a=-3 (8'hFD), b=7 -> r=16'hFFEB.
- Signed a=b=-128 (8'h80) -> r=16'h4000; signed a=0, b=-1 -> r=16'h0000 after the full 8 cycles.
- Backpressure: result ready, out_ready=0 for 5 cycles -> out_valid=1 and r constant throughout, in_ready=0, new in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Reset asserted in BUSY cycle 4 -> next cycle in_ready=1, out_valid=0, r=0; a following 6*7 -> r=16'h002A with normal latency.
- Random regression, WIDTH in {2, 8, 16}, 10k transactions, random mode and random in_valid/out_ready stalls -> every r equals the reference product; no lost or duplicated results.
